// File: rtl/ofd2_ser.sv
// Two-lane MSB-first serializer feeding the ofd2 output register stage.
// A one-word holding buffer in front of the shifter lets words stream with no lane gap.
`timescale 1ns/1ps
module ofd2_ser #(
  parameter int   WIDTH    = 16,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DVAL,
  output logic             DRDY,
  output logic             D0,
  output logic             D1,
  output logic             FRM,
  output logic             BUSY
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(PAIRS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hold;
  logic             hfull;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             load;

  // Accept and load are mutually exclusive: one needs an empty buffer, the other a full one.
  assign accept = DVAL && !hfull;
  assign load   = hfull && ((state == ST_IDLE) || (cnt == '0));
  assign DRDY   = !hfull;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (hfull) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if ((cnt == '0) && !hfull) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Holding buffer, shift register and pair counter.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      hold  <= '0;
      hfull <= 1'b0;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        hold  <= DIN;
        hfull <= 1'b1;
      end else if (load) begin
        hfull <= 1'b0;
      end

      if (load) begin
        sr  <= hold;
        cnt <= CNT_TOP;
      end else if ((state == ST_SHIFT) && (cnt != '0)) begin
        sr  <= {sr[WIDTH-3:0], 2'b00};
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    D0   = IDLE_LVL;
    D1   = IDLE_LVL;
    FRM  = 1'b0;
    BUSY = hfull;
    if (state == ST_SHIFT) begin
      D0   = sr[WIDTH-1];
      D1   = sr[WIDTH-2];
      FRM  = (cnt == CNT_TOP);
      BUSY = 1'b1;
    end
  end

endmodule

// File: tb/tb_ofd2_ser.sv
// Bench for ofd2_ser: a word-level reference model checked every cycle on two
// instances (WIDTH=16/IDLE_LVL=0 and WIDTH=4/IDLE_LVL=1), plus literal lane sequences.
`timescale 1ns/1ps
module tb_ofd2_ser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, dval_a;
  logic [15:0] din_a;
  logic        drdy_a, d0_a, d1_a, frm_a, busy_a;
  logic        rstn_b, dval_b;
  logic [3:0]  din_b;
  logic        drdy_b, d0_b, d1_b, frm_b, busy_b;

  ofd2_ser #(.WIDTH(16), .IDLE_LVL(1'b0)) dut_a (
    .CK(clk), .RSTN(rstn_a), .DIN(din_a), .DVAL(dval_a), .DRDY(drdy_a),
    .D0(d0_a), .D1(d1_a), .FRM(frm_a), .BUSY(busy_a)
  );

  ofd2_ser #(.WIDTH(4), .IDLE_LVL(1'b1)) dut_b (
    .CK(clk), .RSTN(rstn_b), .DIN(din_b), .DVAL(dval_b), .DRDY(drdy_b),
    .D0(d0_b), .D1(d1_b), .FRM(frm_b), .BUSY(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Word-level model: a pending word, the word on the lanes and how many pairs remain.
  logic [15:0] m_hold[2];
  logic [15:0] m_cur[2];
  bit          m_hfull[2] = '{1'b0, 1'b0};
  int          m_left[2]  = '{0, 0};

  function automatic int width_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic logic idle_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic model_reset(input int i);
    m_hfull[i] = 1'b0;
    m_left[i]  = 0;
  endtask

  task automatic model_step(input int i, input logic dv, input logic [15:0] d);
    bit was_full;
    was_full = m_hfull[i];
    if (m_left[i] > 1) begin
      m_left[i] = m_left[i] - 1;
    end else if (m_hfull[i]) begin
      m_cur[i]   = m_hold[i];
      m_left[i]  = width_of(i) / 2;
      m_hfull[i] = 1'b0;
    end else begin
      m_left[i] = 0;
    end
    if (dv && !was_full) begin
      m_hold[i]  = d;
      m_hfull[i] = 1'b1;
    end
  endtask

  function automatic logic e_lane(input int i, input int lane);
    int idx;
    if (m_left[i] == 0) return idle_of(i);
    idx = width_of(i) / 2 - m_left[i];
    return m_cur[i][width_of(i) - 1 - 2 * idx - lane];
  endfunction

  function automatic logic e_frm(input int i);
    return (m_left[i] == width_of(i) / 2);
  endfunction

  function automatic logic e_busy(input int i);
    return (m_left[i] != 0) || m_hfull[i];
  endfunction

  always @(posedge clk or negedge rstn_a) begin
    if (!rstn_a) model_reset(0);
    else model_step(0, dval_a, din_a);
  end

  always @(posedge clk or negedge rstn_b) begin
    if (!rstn_b) model_reset(1);
    else model_step(1, dval_b, {12'h000, din_b});
  end

  always @(negedge clk) begin
    checkOutput("model_d0_a", 16'(d0_a), 16'(e_lane(0, 0)));
    checkOutput("model_d1_a", 16'(d1_a), 16'(e_lane(0, 1)));
    checkOutput("model_frm_a", 16'(frm_a), 16'(e_frm(0)));
    checkOutput("model_busy_a", 16'(busy_a), 16'(e_busy(0)));
    checkOutput("model_drdy_a", 16'(drdy_a), 16'(!m_hfull[0]));
    checkOutput("model_d0_b", 16'(d0_b), 16'(e_lane(1, 0)));
    checkOutput("model_d1_b", 16'(d1_b), 16'(e_lane(1, 1)));
    checkOutput("model_frm_b", 16'(frm_b), 16'(e_frm(1)));
    checkOutput("model_busy_b", 16'(busy_b), 16'(e_busy(1)));
    checkOutput("model_drdy_b", 16'(drdy_b), 16'(!m_hfull[1]));
  end

  bit rec_a = 1'b0;
  bit rec_b = 1'b0;
  bit q_d0a[$], q_d1a[$], q_frma[$];
  bit q_d0b[$], q_d1b[$], q_frmb[$];

  always @(negedge clk) begin
    if (rec_a) begin
      q_d0a.push_back(d0_a); q_d1a.push_back(d1_a); q_frma.push_back(frm_a);
    end
    if (rec_b) begin
      q_d0b.push_back(d0_b); q_d1b.push_back(d1_b); q_frmb.push_back(frm_b);
    end
  end

  // Present a word from a negedge and hold it until accepted; returns the stall count.
  task automatic applyStimulus(input int sel, input logic [15:0] word, output int waits);
    bit acc;
    waits = 0;
    acc   = 1'b0;
    if (sel == 0) begin din_a = word; dval_a = 1'b1; end
    else begin din_b = word[3:0]; dval_b = 1'b1; end
    for (int t = 0; t < 64; t++) begin
      acc = (sel == 0) ? drdy_a : drdy_b;
      @(negedge clk);
      if (acc) break;
      waits++;
    end
    if (!acc) checkOutput("accept_timeout", 16'(acc), 16'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          w;
    int          f;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [15:0] words[3];
    logic [15:0] got;
    int          frm_extra;
    logic [5:0]  eb0, eb1, ebf;

    rstn_a = 1'b0; rstn_b = 1'b0;
    dval_a = 1'b1; din_a = 16'hFFFF;
    dval_b = 1'b0; din_b = 4'h0;
    model_reset(0); model_reset(1);

    #1;
    checkOutput("rst_d0_a", 16'(d0_a), 16'd0);
    checkOutput("rst_d1_a", 16'(d1_a), 16'd0);
    checkOutput("rst_frm_a", 16'(frm_a), 16'd0);
    checkOutput("rst_busy_a", 16'(busy_a), 16'd0);
    checkOutput("rst_drdy_a", 16'(drdy_a), 16'd1);
    checkOutput("rst_d0_b", 16'(d0_b), 16'd1);
    checkOutput("rst_d1_b", 16'(d1_b), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_no_accept_busy", 16'(busy_a), 16'd0);
    checkOutput("rst_no_accept_drdy", 16'(drdy_a), 16'd1);
    @(negedge clk);
    dval_a = 1'b0;
    rstn_a = 1'b1; rstn_b = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy", 16'(busy_a), 16'd0);

    // Single word; DIN changes after acceptance must not leak into the output.
    $display("[TB] single word A5C3");
    applyStimulus(0, 16'hA5C3, w);
    dval_a = 1'b0; din_a = 16'hFFFF;
    checkOutput("single_busy_held", 16'(busy_a), 16'd1);
    checkOutput("single_drdy_held", 16'(drdy_a), 16'd0);
    checkOutput("single_idle_before", 16'(d0_a), 16'd0);
    e0 = 8'b11001001;
    e1 = 8'b00111001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("single_d0_%0d", k), 16'(d0_a), 16'(e0[7-k]));
      checkOutput($sformatf("single_d1_%0d", k), 16'(d1_a), 16'(e1[7-k]));
      checkOutput($sformatf("single_frm_%0d", k), 16'(frm_a), 16'(k == 0));
    end
    @(negedge clk);
    checkOutput("single_after_d0", 16'(d0_a), 16'd0);
    checkOutput("single_after_d1", 16'(d1_a), 16'd0);
    checkOutput("single_after_busy", 16'(busy_a), 16'd0);

    // Back-to-back FFFF, 0000, then 1234 under backpressure.
    $display("[TB] back-to-back stream");
    words[0] = 16'hFFFF; words[1] = 16'h0000; words[2] = 16'h1234;
    rec_a = 1'b1;
    applyStimulus(0, words[0], w);
    checkOutput("b2b_drdy_low", 16'(drdy_a), 16'd0);
    applyStimulus(0, words[1], w);
    checkOutput("b2b_wait_w1", 16'(w), 16'd1);
    applyStimulus(0, words[2], w);
    checkOutput("bp_wait_w2", 16'(w), 16'd7);
    dval_a = 1'b0;
    repeat (30) @(negedge clk);
    rec_a = 1'b0;
    f = -1;
    foreach (q_frma[k]) if (f < 0 && q_frma[k]) f = k;
    if (f < 0 || q_frma.size() < f + 26) begin
      checkOutput("b2b_capture", 16'(q_frma.size()), 16'(f + 26));
    end else begin
      for (int j = 0; j < 3; j++) begin
        got = '0;
        frm_extra = 0;
        for (int p = 0; p < 8; p++) begin
          got[15-2*p] = q_d0a[f+8*j+p];
          got[14-2*p] = q_d1a[f+8*j+p];
          if (p != 0 && q_frma[f+8*j+p]) frm_extra++;
        end
        checkOutput($sformatf("b2b_word_%0d", j), got, words[j]);
        checkOutput($sformatf("b2b_frm_%0d", j), 16'(q_frma[f+8*j]), 16'd1);
        checkOutput($sformatf("b2b_frm_extra_%0d", j), 16'(frm_extra), 16'd0);
      end
      checkOutput("b2b_idle_after", 16'(q_d0a[f+24]), 16'd0);
    end

    // Reset during the 4th pair of A5C3 while FFFF waits in the buffer.
    $display("[TB] reset mid-word");
    applyStimulus(0, 16'hA5C3, w);
    applyStimulus(0, 16'hFFFF, w);
    checkOutput("midrst_wait", 16'(w), 16'd1);
    dval_a = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("midrst_pair4_d0", 16'(d0_a), 16'd0);
    checkOutput("midrst_pair4_d1", 16'(d1_a), 16'd1);
    checkOutput("midrst_hold_full", 16'(drdy_a), 16'd0);
    rstn_a = 1'b0;
    #1;
    checkOutput("midrst_async_d0", 16'(d0_a), 16'd0);
    checkOutput("midrst_async_d1", 16'(d1_a), 16'd0);
    checkOutput("midrst_async_busy", 16'(busy_a), 16'd0);
    checkOutput("midrst_async_drdy", 16'(drdy_a), 16'd1);
    @(posedge clk);
    @(negedge clk);
    rstn_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("midrst_after_d0", 16'(d0_a), 16'd0);
      checkOutput("midrst_after_d1", 16'(d1_a), 16'd0);
      checkOutput("midrst_after_drdy", 16'(drdy_a), 16'd1);
      checkOutput("midrst_after_busy", 16'(busy_a), 16'd0);
    end

    // WIDTH=4, IDLE_LVL=1 instance: stream C then 3.
    $display("[TB] narrow instance C,3");
    rec_b = 1'b1;
    applyStimulus(1, 16'h000C, w);
    applyStimulus(1, 16'h0003, w);
    dval_b = 1'b0;
    repeat (8) @(negedge clk);
    rec_b = 1'b0;
    eb0 = 6'b100111;
    eb1 = 6'b100111;
    ebf = 6'b101000;
    f = -1;
    foreach (q_frmb[k]) if (f < 0 && q_frmb[k]) f = k;
    if (f < 0 || q_frmb.size() < f + 6) begin
      checkOutput("narrow_capture", 16'(q_frmb.size()), 16'(f + 6));
    end else begin
      for (int k = 0; k < 6; k++) begin
        checkOutput($sformatf("narrow_d0_%0d", k), 16'(q_d0b[f+k]), 16'(eb0[5-k]));
        checkOutput($sformatf("narrow_d1_%0d", k), 16'(q_d1b[f+k]), 16'(eb1[5-k]));
        checkOutput($sformatf("narrow_frm_%0d", k), 16'(q_frmb[f+k]), 16'(ebf[5-k]));
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
